calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
Keypad-driven control FSM for the 8-bit add/subtract calculator. Sits between the keypad scanner/input unit and the arithmetic unit. Sequences digit entry, the operand-A/operand-B/result register loads and the display source select, with a parameterised wait for ALU settling.

Parameters:
DIGITS, 3, maximum accepted digits per operand; extra digits are dropped.
ALU_LAT, 2, idle cycles between the load_b_n strobe and the load_r_n strobe (1..15).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
key_valid  in  1  one-cycle pulse: key_code is valid this cycle
key_code  in  4  0x0-0x9 digit; 0xA add; 0xB subtract; 0xE equals; all others ignored
clear_entry  in  1  one-cycle pulse: discard the current operand
clear_all  in  1  level: abort to the initial state
digit_en  out  1  one-cycle pulse: input unit shifts in key_code
entry_clr  out  1  one-cycle pulse: input unit clears its accumulator
load_a_n  out  1  active-low, one-cycle A-register load
load_b_n  out  1  active-low, one-cycle B-register load
load_r_n  out  1  active-low, one-cycle result-register load
add_sub  out  1  0 = add, 1 = subtract; held stable from the operator key until the next operator key
disp_sel  out  1  0 = display entry value, 1 = display result
a_src  out  1  A-register input mux: 0 = entry, 1 = result (constant 0 unless CHAIN_EN)
state_dbg  out  3  current state encoding, for debug LEDs

Behaviour:
- All outputs are registered.
- Reset is synchronous, active-high, on clk.
- Reset values: state = ENTER_A, digit count = 0, add_sub = 0, disp_sel = 0, a_src = 0, load_*_n = 1, digit_en = 0, entry_clr = 1.
- entry_clr deasserts in the first cycle after reset is released.
- States (state_dbg encoding): ENTER_A 000, LOAD_A 001, ENTER_B 010, EXEC 011, SHOW_R 100.
- Timing convention: a key sampled at edge t produces output effects in cycle t+1 unless stated otherwise.
- ENTER_A / ENTER_B:
  - Digit key with count < DIGITS: digit_en = 1 for one cycle, count + 1.
  - Digit key with count == DIGITS: dropped.
- ENTER_A, operator key (0xA/0xB):
  - count > 0: add_sub latched, go to LOAD_A.
  - count == 0: ignored.
  - Equals in ENTER_A: ignored.
- LOAD_A:
  - load_a_n = 0 for exactly 1 cycle (t+1).
  - Then entry_clr = 1 at t+2, count = 0, state = ENTER_B from t+2.
- ENTER_B:
  - Operator key with count == 0: replaces add_sub.
  - Operator key with count > 0: ignored.
  - Equals with count > 0: go to EXEC. Equals with count == 0: ignored.
- EXEC, for equals sampled at t:
  - load_b_n = 0 in cycle t+1.
  - Internal counter waits ALU_LAT cycles.
  - load_r_n = 0 in cycle t+2+ALU_LAT.
  - disp_sel = 1 and state = SHOW_R from t+3+ALU_LAT.
- SHOW_R:
  - Digit key: entry_clr pulse, disp_sel = 0, count = 0, go to ENTER_A. The digit itself is discarded.
  - Equals / operator keys: ignored (see CHAIN_EN).
- Keys arriving in LOAD_A or EXEC are dropped; no buffering.
- clear_entry:
  - In ENTER_A/ENTER_B: entry_clr pulse, count = 0, state unchanged.
  - In all other states: ignored.
- clear_all:
  - Sampled every cycle; beats key_valid and clear_entry.
  - Next state and outputs equal the reset values, including an entry_clr pulse.
  - Mid-EXEC: any pending load_r_n strobe is cancelled.
- Only reset has priority over clear_all.
- Never more than one of load_a_n / load_b_n / load_r_n is low in the same cycle.

Optional Feature:
CALC_SEQ_CHAIN_EN:
- Defined: in SHOW_R an operator key latches add_sub, drives a_src = 1, and goes to LOAD_A. load_a_n loads the result into A; a_src returns to 0 with the entry_clr pulse; the FSM continues in ENTER_B.
- Not defined: a_src is constant 0 and operator keys in SHOW_R are ignored.

Test Plan:
1. Reset held 2 cycles, then released -> state_dbg = 000; all load_*_n = 1; entry_clr = 1 for one cycle after release; disp_sel = 0.
2. Keys 1,2, 0xA, 3, 0xE with ALU_LAT = 2 -> two digit_en pulses; one load_a_n pulse; one digit_en; load_b_n low 1 cycle after 0xE; load_r_n low 4 cycles after 0xE; disp_sel = 1 and state_dbg = 100 one cycle later; add_sub = 0 throughout.
3. Keys 9,9,9,9 with DIGITS = 3 -> exactly 3 digit_en pulses; the 4th key is dropped.
4. 0xA pressed in ENTER_A with no digits -> no load_a_n, state stays 000. 0xA then 0xB in ENTER_B with count 0 -> add_sub = 1.
5. clear_all asserted one cycle after load_b_n -> load_r_n never goes low; next cycle state_dbg = 000, entry_clr = 1.
6. With CALC_SEQ_CHAIN_EN, 0xB in SHOW_R -> a_src = 1 and load_a_n low in the same cycle; then entry_clr pulse with a_src = 0; state_dbg = 010, add_sub = 1. Without the macro -> no change.

Source files
------------

// File: rtl/calc_sequencer.sv
// Keypad sequencing FSM for the 8-bit add/subtract calculator.
// Optional macro CALC_SEQ_CHAIN_EN: an operator key in SHOW_R chains the result into A.
module calc_sequencer #(
    parameter int DIGITS  = 3,
    parameter int ALU_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       clear_entry,
    input  logic       clear_all,
    output logic       digit_en,
    output logic       entry_clr,
    output logic       load_a_n,
    output logic       load_b_n,
    output logic       load_r_n,
    output logic       add_sub,
    output logic       disp_sel,
    output logic       a_src,
    output logic [2:0] state_dbg
);

    localparam int CNT_W = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {
        ENTER_A = 3'b000,
        LOAD_A  = 3'b001,
        ENTER_B = 3'b010,
        EXEC    = 3'b011,
        SHOW_R  = 3'b100
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         lat_q, lat_d;
    logic               digit_en_q, digit_en_d;
    logic               entry_clr_q, entry_clr_d;
    logic               load_a_n_q, load_a_n_d;
    logic               load_b_n_q, load_b_n_d;
    logic               load_r_n_q, load_r_n_d;
    logic               add_sub_q, add_sub_d;
    logic               disp_sel_q, disp_sel_d;
    logic               a_src_q, a_src_d;

    logic is_digit, is_op, is_eq;

    assign is_digit = (key_code <= 4'd9);
    assign is_op    = (key_code == 4'hA) || (key_code == 4'hB);
    assign is_eq    = (key_code == 4'hE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        add_sub_d   = add_sub_q;
        disp_sel_d  = disp_sel_q;
        a_src_d     = a_src_q;
        digit_en_d  = 1'b0;
        entry_clr_d = 1'b0;
        load_a_n_d  = 1'b1;
        load_b_n_d  = 1'b1;
        load_r_n_d  = 1'b1;

        if (clear_all) begin
            state_d     = ENTER_A;
            cnt_d       = '0;
            lat_d       = '0;
            add_sub_d   = 1'b0;
            disp_sel_d  = 1'b0;
            a_src_d     = 1'b0;
            entry_clr_d = 1'b1;
        end else begin
            unique case (state_q)
                ENTER_A, ENTER_B: begin
                    if (clear_entry) begin
                        entry_clr_d = 1'b1;
                        cnt_d       = '0;
                    end else if (key_valid) begin
                        if (is_digit) begin
                            if (cnt_q < CNT_W'(DIGITS)) begin
                                digit_en_d = 1'b1;
                                cnt_d      = cnt_q + 1'b1;
                            end
                        end else if (is_op) begin
                            if (state_q == ENTER_A) begin
                                if (cnt_q != '0) begin
                                    add_sub_d  = key_code[0];
                                    load_a_n_d = 1'b0;
                                    state_d    = LOAD_A;
                                end
                            end else if (cnt_q == '0) begin
                                add_sub_d = key_code[0];
                            end
                        end else if (is_eq && state_q == ENTER_B && cnt_q != '0) begin
                            load_b_n_d = 1'b0;
                            lat_d      = 4'(ALU_LAT);
                            state_d    = EXEC;
                        end
                    end
                end
                LOAD_A: begin
                    entry_clr_d = 1'b1;
                    cnt_d       = '0;
                    a_src_d     = 1'b0;
                    state_d     = ENTER_B;
                end
                EXEC: begin
                    // The registered load_r_n strobe doubles as the "result loaded" marker.
                    if (!load_r_n_q) begin
                        disp_sel_d = 1'b1;
                        state_d    = SHOW_R;
                    end else if (lat_q != '0) begin
                        lat_d = lat_q - 4'd1;
                    end else begin
                        load_r_n_d = 1'b0;
                    end
                end
                SHOW_R: begin
                    if (key_valid) begin
                        if (is_digit) begin
                            entry_clr_d = 1'b1;
                            disp_sel_d  = 1'b0;
                            cnt_d       = '0;
                            state_d     = ENTER_A;
                        end
`ifdef CALC_SEQ_CHAIN_EN
                        else if (is_op) begin
                            add_sub_d  = key_code[0];
                            a_src_d    = 1'b1;
                            load_a_n_d = 1'b0;
                            state_d    = LOAD_A;
                        end
`endif
                    end
                end
                default: state_d = ENTER_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ENTER_A;
            cnt_q       <= '0;
            lat_q       <= '0;
            digit_en_q  <= 1'b0;
            entry_clr_q <= 1'b1;
            load_a_n_q  <= 1'b1;
            load_b_n_q  <= 1'b1;
            load_r_n_q  <= 1'b1;
            add_sub_q   <= 1'b0;
            disp_sel_q  <= 1'b0;
            a_src_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            digit_en_q  <= digit_en_d;
            entry_clr_q <= entry_clr_d;
            load_a_n_q  <= load_a_n_d;
            load_b_n_q  <= load_b_n_d;
            load_r_n_q  <= load_r_n_d;
            add_sub_q   <= add_sub_d;
            disp_sel_q  <= disp_sel_d;
            a_src_q     <= a_src_d;
        end
    end

    assign digit_en  = digit_en_q;
    assign entry_clr = entry_clr_q;
    assign load_a_n  = load_a_n_q;
    assign load_b_n  = load_b_n_q;
    assign load_r_n  = load_r_n_q;
    assign add_sub   = add_sub_q;
    assign disp_sel  = disp_sel_q;
    assign a_src     = a_src_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed testbench for calc_sequencer (DIGITS = 3, ALU_LAT = 2).
module tb_calc_sequencer;

    logic       clk;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       clear_entry;
    logic       clear_all;
    logic       digit_en;
    logic       entry_clr;
    logic       load_a_n;
    logic       load_b_n;
    logic       load_r_n;
    logic       add_sub;
    logic       disp_sel;
    logic       a_src;
    logic [2:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int overlap_err = 0;

    calc_sequencer #(.DIGITS(3), .ALU_LAT(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .clear_entry (clear_entry),
        .clear_all   (clear_all),
        .digit_en    (digit_en),
        .entry_clr   (entry_clr),
        .load_a_n    (load_a_n),
        .load_b_n    (load_b_n),
        .load_r_n    (load_r_n),
        .add_sub     (add_sub),
        .disp_sel    (disp_sel),
        .a_src       (a_src),
        .state_dbg   (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (!reset && ((!load_a_n && !load_b_n) || (!load_a_n && !load_r_n) || (!load_b_n && !load_r_n)))
            overlap_err = overlap_err + 1;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key_code  = code;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic do_clear_all();
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        tick();
    endtask

    initial begin
        int pulses;
        reset       = 1'b1;
        key_valid   = 1'b0;
        key_code    = 4'h0;
        clear_entry = 1'b0;
        clear_all   = 1'b0;

        // 1: reset
        tick();
        tick();
        reset = 1'b0;
        chk("rst_state",     8'(state_dbg), 8'd0);
        chk("rst_load_a",    8'(load_a_n),  8'd1);
        chk("rst_load_b",    8'(load_b_n),  8'd1);
        chk("rst_load_r",    8'(load_r_n),  8'd1);
        chk("rst_entry_clr", 8'(entry_clr), 8'd1);
        chk("rst_disp",      8'(disp_sel),  8'd0);
        chk("rst_add_sub",   8'(add_sub),   8'd0);
        chk("rst_a_src",     8'(a_src),     8'd0);
        tick();
        chk("rst_clr_drop",  8'(entry_clr), 8'd0);

        // 2: 1 2 + 3 =
        press(4'h1);
        chk("d1_en", 8'(digit_en), 8'd1);
        tick();
        chk("d1_en_off", 8'(digit_en), 8'd0);
        press(4'h2);
        chk("d2_en", 8'(digit_en), 8'd1);
        press(4'hA);
        chk("opA_load_a", 8'(load_a_n),  8'd0);
        chk("opA_state",  8'(state_dbg), 8'd1);
        tick();
        chk("lda_release", 8'(load_a_n),  8'd1);
        chk("lda_clr",     8'(entry_clr), 8'd1);
        chk("lda_state",   8'(state_dbg), 8'd2);
        tick();
        press(4'h3);
        chk("d3_en", 8'(digit_en), 8'd1);
        press(4'hE);
        chk("eq_load_b", 8'(load_b_n),  8'd0);
        chk("eq_state",  8'(state_dbg), 8'd3);
        tick();
        chk("exec_b_off", 8'(load_b_n), 8'd1);
        chk("exec_r_w1",  8'(load_r_n), 8'd1);
        tick();
        chk("exec_r_w2",  8'(load_r_n), 8'd1);
        tick();
        chk("exec_load_r", 8'(load_r_n), 8'd0);
        chk("exec_disp0",  8'(disp_sel), 8'd0);
        tick();
        chk("show_disp",   8'(disp_sel),  8'd1);
        chk("show_state",  8'(state_dbg), 8'd4);
        chk("show_r_off",  8'(load_r_n),  8'd1);
        chk("show_addsub", 8'(add_sub),   8'd0);

        // 3: digit from SHOW_R restarts, then 9 9 9 9
        press(4'h9);
        chk("restart_clr",   8'(entry_clr), 8'd1);
        chk("restart_state", 8'(state_dbg), 8'd0);
        chk("restart_disp",  8'(disp_sel),  8'd0);
        chk("restart_no_en", 8'(digit_en),  8'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            press(4'h9);
            if (digit_en) pulses++;
        end
        chk("max_digits", 8'(pulses), 8'd3);

        // clear_entry resets the count
        clear_entry = 1'b1;
        tick();
        clear_entry = 1'b0;
        chk("ce_clr",   8'(entry_clr), 8'd1);
        chk("ce_state", 8'(state_dbg), 8'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            press(4'h4);
            if (digit_en) pulses++;
        end
        chk("ce_digits", 8'(pulses), 8'd3);

        // 4: operator with empty entry
        do_clear_all();
        press(4'hA);
        chk("op_empty_load_a", 8'(load_a_n),  8'd1);
        chk("op_empty_state",  8'(state_dbg), 8'd0);
        press(4'hE);
        chk("eq_in_a_state",   8'(state_dbg), 8'd0);
        press(4'h5);
        press(4'hA);
        chk("op_b_load_a", 8'(load_a_n), 8'd0);
        tick();
        press(4'hA);
        chk("opB_add",   8'(add_sub),   8'd0);
        press(4'hB);
        chk("opB_sub",   8'(add_sub),   8'd1);
        chk("opB_state", 8'(state_dbg), 8'd2);
        press(4'hE);
        chk("eq_empty_state",  8'(state_dbg), 8'd2);
        chk("eq_empty_load_b", 8'(load_b_n),  8'd1);

        // 5: clear_all in EXEC cancels load_r
        press(4'h7);
        press(4'hE);
        chk("abort_load_b", 8'(load_b_n), 8'd0);
        tick();
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        chk("abort_state",  8'(state_dbg), 8'd0);
        chk("abort_clr",    8'(entry_clr), 8'd1);
        chk("abort_addsub", 8'(add_sub),   8'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!load_r_n) pulses++;
        end
        chk("abort_no_load_r", 8'(pulses), 8'd0);

        // 6: operator in SHOW_R
        press(4'h4);
        press(4'hA);
        tick();
        press(4'h2);
        press(4'hE);
        for (int i = 0; i < 4; i++) tick();
        chk("chain_show", 8'(state_dbg), 8'd4);
        press(4'hB);
`ifdef CALC_SEQ_CHAIN_EN
        chk("chain_a_src",  8'(a_src),     8'd1);
        chk("chain_load_a", 8'(load_a_n),  8'd0);
        chk("chain_state1", 8'(state_dbg), 8'd1);
        chk("chain_addsub", 8'(add_sub),   8'd1);
        tick();
        chk("chain_clr",    8'(entry_clr), 8'd1);
        chk("chain_a_src0", 8'(a_src),     8'd0);
        chk("chain_state2", 8'(state_dbg), 8'd2);
`else
        chk("nochain_state",  8'(state_dbg), 8'd4);
        chk("nochain_load_a", 8'(load_a_n),  8'd1);
        chk("nochain_a_src",  8'(a_src),     8'd0);
        chk("nochain_addsub", 8'(add_sub),   8'd0);
        tick();
        chk("nochain_hold",   8'(state_dbg), 8'd4);
`endif

        chk("load_exclusive", 8'(overlap_err), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
